// File: rtl/irq_sched.sv
// irq_sched: sticky-pending interrupt scheduler with a mask, highest-index
// priority arbitration and a req/ack/eoi handshake towards the core.
module irq_sched #(
  parameter int NUM_SRC = 8,
  localparam int VEC_W = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vec,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] in_service
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [NUM_SRC-1:0] irq_prev_reg;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] elig;
  logic [VEC_W-1:0]   winner;
  logic [NUM_SRC-1:0] vec_onehot;
  logic [NUM_SRC-1:0] ack_clr;
  logic               ack_take;
  logic [NUM_SRC-1:0] pending_next;

  assign edge_det   = irq_in & ~irq_prev_reg;
  assign elig       = pending & ~mask;
  assign vec_onehot = NUM_SRC'(1) << irq_vec;
  // An ack only counts while a request is actually outstanding.
  assign ack_take   = (state_reg == REQ) && irq_ack;
  assign ack_clr    = ack_take ? vec_onehot : '0;
  // A new edge on the acknowledged source wins over the clear.
  assign pending_next = (pending & ~ack_clr) | edge_det;

  // Priority pick: ascending scan so the highest set index wins.
  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig[i]) winner = VEC_W'(i);
    end
  end

  // Edge history, pending bits and mask register.
  always_ff @(posedge clk) begin
    irq_prev_reg <= irq_in;
    if (rst) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= pending_next;
      if (mask_we) mask <= mask_wdata;
    end
  end

  // Handshake FSM with registered request, vector and in-service outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      irq_req    <= 1'b0;
      irq_vec    <= '0;
      in_service <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (elig != '0) begin
            irq_vec   <= winner;
            irq_req   <= 1'b1;
            state_reg <= REQ;
          end
        end
        REQ: begin
          // Vector stays frozen here even if priorities or mask change.
          if (irq_ack) begin
            irq_req    <= 1'b0;
            in_service <= vec_onehot;
            state_reg  <= SVC;
          end
        end
        SVC: begin
          if (eoi) begin
            in_service <= '0;
            state_reg  <= IDLE;
          end
        end
        default: begin
          irq_req    <= 1'b0;
          in_service <= '0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

endmodule
